// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the CPU control unit (master) and alu_seq_ctrl (slave).
//   master drives start/op/a/b; slave returns busy/done/result/result_hi/zero/illegal.
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             illegal;
  modport master(output start, op, a, b, input busy, done, result, result_hi, zero, illegal);
  modport slave(input start, op, a, b, output busy, done, result, result_hi, zero, illegal);
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences one ALU op at a time on latched operands (AND/OR/XOR/ADD/SUB/SLT, optional shift-and-add MUL).
//   clk, reset (async, active-high); bus (alu_seq_if.slave): start/op/a/b in, busy/done/result/result_hi/zero/illegal out.
//   Define ALU_SEQ_MUL_EN to build the iterative unsigned multiplier; otherwise op 110 completes as illegal like op 111.
module alu_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
`else
  typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif
  state_t           state, nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, exec_res;
  logic             exec_ill;
  logic             accept;
  assign accept   = state == IDLE && bus.start;
  assign bus.busy = state != IDLE;
`ifdef ALU_SEQ_MUL_EN
  // b_q doubles as the multiplier register; the low product bits shift in from the top as it drains
  assign sum  = {1'b0, acc_hi} + (b_q[0] ? {1'b0, a_q} : '0);
  assign prod = {sum, b_q[WIDTH-1:1]};
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
`ifdef ALU_SEQ_MUL_EN
    nxt = state == IDLE ? (bus.start ? (bus.op == 3'b110 ? MUL : EXEC) : IDLE)
        : (state == MUL && cnt != LAST) ? MUL : IDLE;
`else
    nxt = accept ? EXEC : IDLE;
`endif
  end
  always_comb begin
    exec_res = '0;
    exec_ill = 1'b0;
    case (op_q)
      3'b000:  exec_res = a_q & b_q;
      3'b001:  exec_res = a_q | b_q;
      3'b010:  exec_res = a_q ^ b_q;
      3'b011:  exec_res = a_q + b_q;
      3'b100:  exec_res = a_q - b_q;
      3'b101:  exec_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      default: exec_ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.result_hi <= '0;
      bus.zero      <= 1'b1;
      bus.illegal   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_hi        <= '0;
      cnt           <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        op_q <= bus.op;
        a_q  <= bus.a;
        b_q  <= bus.b;
      end
      if (state == EXEC) begin
        bus.result    <= exec_res;
        bus.result_hi <= '0;
        bus.zero      <= exec_res == '0;
        bus.illegal   <= exec_ill;
        bus.done      <= 1'b1;
      end
`ifdef ALU_SEQ_MUL_EN
      if (accept) begin
        acc_hi <= '0;
        cnt    <= '0;
      end
      if (state == MUL) begin
        acc_hi <= sum[WIDTH:1];
        b_q    <= prod[WIDTH-1:0];
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) begin
          bus.result    <= prod[WIDTH-1:0];
          bus.result_hi <= prod[2*WIDTH-1:WIDTH];
          bus.zero      <= prod == '0;
          bus.illegal   <= 1'b0;
          bus.done      <= 1'b1;
        end
      end
`endif
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench for alu_seq_ctrl with a reference model and randomized ops.
module tb_alu_seq_ctrl;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        ill;
    int          acc;
    int          dn;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];
  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq_ctrl #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    e.hi = '0;
    e.ill = 1'b0;
    e.lo = '0;
    p = '0;
    case (op)
      3'd0: e.lo = a & b;
      3'd1: e.lo = a | b;
      3'd2: e.lo = a ^ b;
      3'd3: e.lo = a + b;
      3'd4: e.lo = a - b;
      3'd5: e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: if (MUL_EN) begin
              p = {32'd0, a} * {32'd0, b};
              e.lo = p[31:0];
              e.hi = p[63:32];
            end else e.ill = 1'b1;
      default: e.ill = 1'b1;
    endcase
    e.zero = {e.hi, e.lo} == 64'd0;
    e.acc = 0;
    e.dn = (op == 3'd6 && MUL_EN) ? 32 : 1;
    return e;
  endfunction
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      $display("FAIL busy_timeout: busy still %b after %0d cycles, expected 0", bus.busy, n);
      $fatal(1);
    end
    #1;
    e = model(op, a, b);
    e.acc = cyc + 1;
    e.dn = e.acc + e.dn;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 3'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (sb.size() > 0 && cyc > sb[0].acc && cyc < sb[0].dn) chk("busy_in_flight", 64'(bus.busy), 64'd1);
      if (bus.done) begin
        chk("done_width", 64'(prev_done), 64'd0);
        if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", 64'(cyc), 64'(e.dn));
          chk("result", 64'(bus.result), 64'(e.lo));
          chk("result_hi", 64'(bus.result_hi), 64'(e.hi));
          chk("zero", 64'(bus.zero), 64'(e.zero));
          chk("illegal", 64'(bus.illegal), 64'(e.ill));
          chk("busy_at_done", 64'(bus.busy), 64'd0);
        end
      end
    end
    prev_done <= bus.done;
  end
  initial begin
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_result_hi", 64'(bus.result_hi), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd1);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    issue(3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    issue(3'd2, 32'h5A5A_A5A5, 32'h5A5A_A5A5);
    issue(3'd3, 32'hFFFF_FFFF, 32'd1);
    issue(3'd4, 32'd0, 32'd1);
    issue(3'd5, 32'h8000_0000, 32'd1);
    issue(3'd5, 32'd5, 32'd5);
    issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd6, 32'd0, 32'h1234);
    issue(3'd6, 32'h0001_0003, 32'h0000_0007);
    for (int i = 0; i < 100 && bus.busy; i++) begin
      bus.start = 1'b1;
      bus.op = 3'($urandom);
      bus.a = $urandom;
      bus.b = $urandom;
      @(negedge clk);
    end
    bus.start = 1'b0;
    issue(3'd3, 32'h1111_1111, 32'h2222_2222);
    issue(3'd3, 32'h7FFF_FFFF, 32'd1);
    issue(3'd6, 32'hDEAD_BEEF, 32'h0001_2345);
    repeat (MUL_EN ? 10 : 2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_result", 64'(bus.result), 64'd0);
    chk("midrst_result_hi", 64'(bus.result_hi), 64'd0);
    chk("midrst_zero", 64'(bus.zero), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    issue(3'd1, 32'd1, 32'd2);
    issue(3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(3'd6, 32'h0000_0003, 32'h0000_0005);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      issue(3'($urandom_range(0, 7)), a, b);
    end
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    chk("drain_pending", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
